// File: rtl/dds_wave_meter_pkg.sv
// dds_wave_meter_pkg
//   Shared definitions for the DDS receive-side measurement slice:
//   - default sample width and midscale threshold of the DDS stream
//   - measurement FSM state encoding
//   - Schmitt trigger level encoding
//   - small helper for saturating counter increments
//   Imported by dds_schmitt_edge and dds_wave_meter.

package dds_wave_meter_pkg;

  // Default DDS sample width (unsigned offset-binary) and midscale code.
  localparam int DDS_DW  = 12;
  localparam int DDS_MID = 2048;

  // Measurement window sequencing.
  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_MEAS = 2'd1,
    ST_DONE = 2'd2
  } meter_state_t;

  // Schmitt trigger output level. UNSET means no sample has been seen yet
  // in this window, so no edge can be reported on the next sample.
  typedef enum logic [1:0] {
    LVL_UNSET = 2'd0,
    LVL_LO    = 2'd1,
    LVL_HI    = 2'd2
  } schmitt_level_t;

  // Returns 1 when an unsigned counter value is at its all-ones ceiling.
  // The counter width is passed as a run-time value so the helper works
  // for any width up to 32 bits.
  function automatic logic is_saturated(input logic [31:0] value, input int width);
    logic [31:0] ceiling;
    ceiling = (width >= 32) ? 32'hFFFF_FFFF : ((32'd1 << width) - 32'd1);
    return (value == ceiling);
  endfunction

endpackage

// File: rtl/dds_wave_meter_schmitt_edge.sv
// dds_schmitt_edge
//   Schmitt trigger with hysteresis around a midscale threshold, reporting
//   rising crossings of the DDS sample stream.
//   The first qualified sample after init only sets the level (HI if
//   din >= MID, else LO). After that, LO -> HI needs din >= MID+HYST and
//   emits a one-cycle rise pulse; HI -> LO needs din < MID-HYST.
//   rise is combinational for the sample currently presented, so the
//   caller can tag the event with that sample's index.
// Ports
//   clk      in   1    system clock
//   rst_n    in   1    asynchronous active-low reset
//   init     in   1    return level to UNSET (start of a new window)
//   din_vld  in   1    sample qualifier; level only moves on qualified samples
//   din      in   DW   sample, unsigned offset-binary
//   level    out  2    current Schmitt level (schmitt_level_t)
//   rise     out  1    rising crossing on the presented sample

module dds_schmitt_edge
  import dds_wave_meter_pkg::*;
#(
  parameter int DW   = DDS_DW,
  parameter int MID  = DDS_MID,
  parameter int HYST = 64
) (
  input  logic           clk,
  input  logic           rst_n,
  input  logic           init,
  input  logic           din_vld,
  input  logic [DW-1:0]  din,
  output schmitt_level_t level,
  output logic           rise
);

  localparam logic [DW-1:0] TH_MID = DW'(MID);
  localparam logic [DW-1:0] TH_HI  = DW'(MID + HYST);
  localparam logic [DW-1:0] TH_LO  = DW'(MID - HYST);

  schmitt_level_t level_q;
  schmitt_level_t level_d;

  // Level update and rise detection for the presented sample.
  always_comb begin
    level_d = level_q;
    rise    = 1'b0;
    if (init) begin
      level_d = LVL_UNSET;
    end else if (din_vld) begin
      case (level_q)
        LVL_UNSET: level_d = (din >= TH_MID) ? LVL_HI : LVL_LO;
        LVL_LO: begin
          if (din >= TH_HI) begin
            level_d = LVL_HI;
            rise    = 1'b1;
          end
        end
        LVL_HI: begin
          if (din < TH_LO) begin
            level_d = LVL_LO;
          end
        end
        default: level_d = LVL_UNSET;
      endcase
    end
  end

  // Level register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      level_q <= LVL_UNSET;
    end else begin
      level_q <= level_d;
    end
  end

  assign level = level_q;

endmodule

// File: rtl/dds_wave_meter.sv
// dds_wave_meter
//   Receive-side measurement of the DDS sample stream. Over a window of
//   WIN_LEN qualified samples it records max, min, peak-to-peak, and the
//   number and index span of rising midscale crossings (with hysteresis)
//   so a status path can estimate the signal period.
// Ports
//   clk      in   1    system clock
//   rst_n    in   1    asynchronous active-low reset
//   start    in   1    one-cycle request to begin a window; ignored while busy
//   clr      in   1    synchronous abort to IDLE; results untouched; beats start
//   din_vld  in   1    din qualifier
//   din      in   DW   DDS sample, unsigned offset-binary
//   busy     out  1    window in progress
//   done     out  1    one-cycle pulse; results change on this cycle
//   vmax     out  DW   largest sample of the window
//   vmin     out  DW   smallest sample of the window
//   vpp      out  DW   vmax - vmin
//   n_cross  out  CW   rising crossings, saturating at 2^CW-1
//   span     out  CW   index of last rising crossing minus first; 0 if n_cross<2
//   no_sig   out  1    n_cross<2, no period can be derived

module dds_wave_meter
  import dds_wave_meter_pkg::*;
#(
  parameter int DW      = DDS_DW,
  parameter int WIN_LEN = 4096,
  parameter int CW      = 16,
  parameter int MID     = DDS_MID,
  parameter int HYST    = 64
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          start,
  input  logic          clr,
  input  logic          din_vld,
  input  logic [DW-1:0] din,
  output logic          busy,
  output logic          done,
  output logic [DW-1:0] vmax,
  output logic [DW-1:0] vmin,
  output logic [DW-1:0] vpp,
  output logic [CW-1:0] n_cross,
  output logic [CW-1:0] span,
  output logic          no_sig
);

  // Reject parameter sets the thresholds or counters cannot represent.
  if (HYST > MID) begin : g_bad_hyst_lo
    $error("dds_wave_meter: HYST must not exceed MID");
  end
  if (MID + HYST > (1 << DW) - 1) begin : g_bad_hyst_hi
    $error("dds_wave_meter: MID+HYST must fit in DW bits");
  end
  if (WIN_LEN < 2 || WIN_LEN > (1 << CW) - 1) begin : g_bad_win
    $error("dds_wave_meter: WIN_LEN must be in 2..2^CW-1");
  end

  localparam logic [CW-1:0] LAST_IDX = CW'(WIN_LEN - 1);
  localparam logic [CW-1:0] TWO      = CW'(2);

  meter_state_t state_q;
  meter_state_t state_d;

  logic          accept;
  logic          meas_vld;
  logic          finish;

  logic [CW-1:0] idx_q;
  logic [DW-1:0] wmax_q;
  logic [DW-1:0] wmin_q;
  logic [CW-1:0] cnt_q;
  logic [CW-1:0] first_q;
  logic [CW-1:0] last_q;

  logic           sch_rise;
  schmitt_level_t sch_level_unused;

  // A window begins only from IDLE, and clr always wins over start.
  assign accept   = (state_q == ST_IDLE) && start && !clr;
  // Samples are only taken inside a window; an aborting cycle takes none.
  assign meas_vld = (state_q == ST_MEAS) && din_vld && !clr;
  // The DONE cycle publishes results unless it is being aborted.
  assign finish   = (state_q == ST_DONE) && !clr;

  // State register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= ST_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // Next-state logic; clr overrides every transition.
  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE: begin
        if (start) begin
          state_d = ST_MEAS;
        end
      end
      ST_MEAS: begin
        if (din_vld && (idx_q == LAST_IDX)) begin
          state_d = ST_DONE;
        end
      end
      ST_DONE: state_d = ST_IDLE;
      default: state_d = ST_IDLE;
    endcase
    if (clr) begin
      state_d = ST_IDLE;
    end
  end

  // The Schmitt level is only meaningful inside the edge detector; the
  // meter consumes just the rise pulse.
  dds_schmitt_edge #(
    .DW   (DW),
    .MID  (MID),
    .HYST (HYST)
  ) u_schmitt (
    .clk     (clk),
    .rst_n   (rst_n),
    .init    (accept),
    .din_vld (meas_vld),
    .din     (din),
    .level   (sch_level_unused),
    .rise    (sch_rise)
  );

  // Working state of the current window. Everything is re-initialised on
  // start, so an aborted window leaves nothing behind that matters.
  // first/last record the index of the sample that caused the rise.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      idx_q   <= '0;
      wmax_q  <= '0;
      wmin_q  <= '1;
      cnt_q   <= '0;
      first_q <= '0;
      last_q  <= '0;
    end else if (accept) begin
      idx_q   <= '0;
      wmax_q  <= '0;
      wmin_q  <= '1;
      cnt_q   <= '0;
      first_q <= '0;
      last_q  <= '0;
    end else if (meas_vld) begin
      idx_q <= idx_q + CW'(1);
      if (din > wmax_q) begin
        wmax_q <= din;
      end
      if (din < wmin_q) begin
        wmin_q <= din;
      end
      if (sch_rise) begin
        if (cnt_q == '0) begin
          first_q <= idx_q;
        end
        last_q <= idx_q;
        if (!is_saturated(32'(cnt_q), CW)) begin
          cnt_q <= cnt_q + CW'(1);
        end
      end
    end
  end

  // Result registers; they only change together with the done pulse and
  // otherwise hold the last completed window.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      done    <= 1'b0;
      vmax    <= '0;
      vmin    <= '0;
      vpp     <= '0;
      n_cross <= '0;
      span    <= '0;
      no_sig  <= 1'b0;
    end else begin
      done <= finish;
      if (finish) begin
        vmax    <= wmax_q;
        vmin    <= wmin_q;
        vpp     <= wmax_q - wmin_q;
        n_cross <= cnt_q;
        span    <= (cnt_q >= TWO) ? (last_q - first_q) : '0;
        no_sig  <= (cnt_q < TWO);
      end
    end
  end

  assign busy = (state_q == ST_MEAS);

endmodule

// File: tb/tb_dds_wave_meter.sv
// tb_dds_wave_meter
//   Self-checking bench for dds_wave_meter with a 64-sample window.
//   Directed cases use hand-derived constants; randomized windows are
//   compared against a behavioural model working on a queue of samples.

module tb_dds_wave_meter;

  localparam int DW   = 12;
  localparam int WIN  = 64;
  localparam int CW   = 16;
  localparam int MID  = 2048;
  localparam int HYST = 64;

  logic          clk     = 1'b0;
  logic          rst_n   = 1'b0;
  logic          start   = 1'b0;
  logic          clr     = 1'b0;
  logic          din_vld = 1'b0;
  logic [DW-1:0] din     = '0;
  logic          busy;
  logic          done;
  logic [DW-1:0] vmax;
  logic [DW-1:0] vmin;
  logic [DW-1:0] vpp;
  logic [CW-1:0] n_cross;
  logic [CW-1:0] span;
  logic          no_sig;

  int checks = 0;
  int passes = 0;

  // Observations captured by run_window.
  logic          o_early;
  logic          o_busy_ok;
  logic          o_done_now;
  logic          o_done_next;
  logic          o_busy_at_done;
  logic [DW-1:0] o_max;
  logic [DW-1:0] o_min;
  logic [DW-1:0] o_vpp;
  logic [CW-1:0] o_cross;
  logic [CW-1:0] o_span;
  logic          o_nosig;

  always #5 clk = ~clk;

  dds_wave_meter #(
    .DW      (DW),
    .WIN_LEN (WIN),
    .CW      (CW),
    .MID     (MID),
    .HYST    (HYST)
  ) dut (
    .clk     (clk),
    .rst_n   (rst_n),
    .start   (start),
    .clr     (clr),
    .din_vld (din_vld),
    .din     (din),
    .busy    (busy),
    .done    (done),
    .vmax    (vmax),
    .vmin    (vmin),
    .vpp     (vpp),
    .n_cross (n_cross),
    .span    (span),
    .no_sig  (no_sig)
  );

  // Reference: statistics of one window from its list of valid samples.
  function automatic void model(input int q[$], output int emax, output int emin,
                                output int ecross, output int espan);
    int lvl;
    int first;
    int last;
    lvl = -1; first = 0; last = 0;
    emax = 0; emin = 4095; ecross = 0;
    foreach (q[i]) begin
      if (q[i] > emax) emax = q[i];
      if (q[i] < emin) emin = q[i];
      if (lvl < 0) begin
        lvl = (q[i] >= MID) ? 1 : 0;
      end else if (lvl == 0 && q[i] >= MID + HYST) begin
        lvl = 1;
        if (ecross == 0) first = i;
        last = i;
        if (ecross < 65535) ecross++;
      end else if (lvl == 1 && q[i] < MID - HYST) begin
        lvl = 0;
      end
    end
    espan = (ecross >= 2) ? last - first : 0;
  endfunction

  function automatic void square_wave(output int q[$]);
    q = {};
    for (int i = 0; i < WIN; i++) q.push_back(((i % 16) < 8) ? 0 : 4095);
  endfunction

  function automatic void gen_wave(input int kind, output int q[$]);
    int p, a, off, lo, hi, duty, ph, v;
    q = {};
    p    = $urandom_range(6, 24);
    a    = $urandom_range(100, 2047);
    off  = $urandom_range(0, 23);
    lo   = $urandom_range(0, 2047);
    hi   = $urandom_range(2048, 4095);
    duty = $urandom_range(1, p - 1);
    for (int i = 0; i < WIN; i++) begin
      ph = (i + off) % p;
      case (kind)
        0: v = $urandom_range(0, 4095);
        1: v = MID - a + ((ph < p / 2) ? (ph * 2 * a) / (p / 2)
                                        : ((p - ph) * 2 * a) / (p - p / 2));
        2: v = (ph < duty) ? hi : lo;
        default: v = MID - 150 + $urandom_range(0, 300);
      endcase
      if (v < 0) v = 0;
      if (v > 4095) v = 4095;
      q.push_back(v);
    end
  endfunction

  // Drives one full window and captures timing flags and results.
  // gap_mode 0: din_vld always high; 1: one idle cycle before each sample;
  // 2: 0..2 random idle cycles before each sample.
  task automatic run_window(input int q[$], input int gap_mode, input int start_at);
    int gaps;
    o_early = 1'b0;
    o_busy_ok = 1'b1;
    @(negedge clk); start = 1'b1; din_vld = 1'b0;
    @(negedge clk); start = 1'b0;
    for (int i = 0; i < WIN; i++) begin
      gaps = (gap_mode == 1) ? 1 : (gap_mode == 2) ? $urandom_range(0, 2) : 0;
      for (int g = 0; g < gaps; g++) begin
        din_vld = 1'b0; start = 1'b0; din = DW'($urandom);
        @(negedge clk);
        if (!busy) o_busy_ok = 1'b0;
        if (done) o_early = 1'b1;
      end
      din_vld = 1'b1; din = DW'(q[i]); start = (i == start_at);
      @(negedge clk);
      if (i < WIN - 1 && !busy) o_busy_ok = 1'b0;
      if (done) o_early = 1'b1;
    end
    din_vld = 1'b0; start = 1'b0;
    @(negedge clk);
    o_done_now = done; o_busy_at_done = busy;
    o_max = vmax; o_min = vmin; o_vpp = vpp;
    o_cross = n_cross; o_span = span; o_nosig = no_sig;
    @(negedge clk);
    o_done_next = done;
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    repeat (2) @(negedge clk);
    checks++; if (busy !== 1'b0) $display("[TB] FAIL reset_busy got %0b want 0", busy); else passes++;
    checks++; if (done !== 1'b0) $display("[TB] FAIL reset_done got %0b want 0", done); else passes++;
    checks++; if (vmax !== '0) $display("[TB] FAIL reset_vmax got %0d want 0", vmax); else passes++;
    checks++; if (vmin !== '0) $display("[TB] FAIL reset_vmin got %0d want 0", vmin); else passes++;
    checks++; if (vpp !== '0) $display("[TB] FAIL reset_vpp got %0d want 0", vpp); else passes++;
    checks++; if (n_cross !== '0) $display("[TB] FAIL reset_ncross got %0d want 0", n_cross); else passes++;
    checks++; if (span !== '0) $display("[TB] FAIL reset_span got %0d want 0", span); else passes++;
    checks++; if (no_sig !== 1'b0) $display("[TB] FAIL reset_nosig got %0b want 0", no_sig); else passes++;
    rst_n = 1'b1;
    repeat (2) @(negedge clk);
    checks++; if (busy !== 1'b0 || done !== 1'b0)
      $display("[TB] FAIL idle_after_reset got busy=%0b done=%0b want 0 0", busy, done); else passes++;
  endtask

  // Square wave, optionally gapped; a start pulse mid-window must be ignored.
  task automatic test_square(input int gap_mode, input string tag);
    int q[$];
    square_wave(q);
    run_window(q, gap_mode, 20);
    checks++; if (o_early !== 1'b0) $display("[TB] FAIL %s_early_done got 1 want 0", tag); else passes++;
    checks++; if (o_busy_ok !== 1'b1) $display("[TB] FAIL %s_busy got 0 want 1", tag); else passes++;
    checks++; if (o_done_now !== 1'b1 || o_busy_at_done !== 1'b0)
      $display("[TB] FAIL %s_done_latency got done=%0b busy=%0b want 1 0", tag, o_done_now, o_busy_at_done); else passes++;
    checks++; if (o_done_next !== 1'b0) $display("[TB] FAIL %s_done_pulse got 1 want 0", tag); else passes++;
    checks++; if (o_max !== 12'd4095) $display("[TB] FAIL %s_vmax got %0d want 4095", tag, o_max); else passes++;
    checks++; if (o_min !== 12'd0) $display("[TB] FAIL %s_vmin got %0d want 0", tag, o_min); else passes++;
    checks++; if (o_vpp !== 12'd4095) $display("[TB] FAIL %s_vpp got %0d want 4095", tag, o_vpp); else passes++;
    checks++; if (o_cross !== 16'd4) $display("[TB] FAIL %s_ncross got %0d want 4", tag, o_cross); else passes++;
    checks++; if (o_span !== 16'd48) $display("[TB] FAIL %s_span got %0d want 48", tag, o_span); else passes++;
    checks++; if (o_nosig !== 1'b0) $display("[TB] FAIL %s_nosig got %0b want 0", tag, o_nosig); else passes++;
  endtask

  // Flat and in-hysteresis signals: no crossings, no_sig set.
  task automatic test_no_signal();
    int q[$];
    int exp_max [2] = '{2048, 2100};
    int exp_min [2] = '{2048, 2040};
    for (int c = 0; c < 2; c++) begin
      q = {};
      for (int i = 0; i < WIN; i++) q.push_back((c == 0) ? 2048 : ((i % 2) ? 2100 : 2040));
      run_window(q, 0, -1);
      checks++; if (o_done_now !== 1'b1) $display("[TB] FAIL nosig%0d_done got 0 want 1", c); else passes++;
      checks++; if (o_max !== DW'(exp_max[c]) || o_min !== DW'(exp_min[c]))
        $display("[TB] FAIL nosig%0d_maxmin got %0d/%0d want %0d/%0d", c, o_max, o_min, exp_max[c], exp_min[c]); else passes++;
      checks++; if (o_vpp !== DW'(exp_max[c] - exp_min[c]))
        $display("[TB] FAIL nosig%0d_vpp got %0d want %0d", c, o_vpp, exp_max[c] - exp_min[c]); else passes++;
      checks++; if (o_cross !== '0 || o_span !== '0 || o_nosig !== 1'b1)
        $display("[TB] FAIL nosig%0d_cross got n=%0d span=%0d nosig=%0b want 0 0 1", c, o_cross, o_span, o_nosig); else passes++;
    end
  endtask

  task automatic test_random();
    int q[$];
    int emax, emin, ecross, espan;
    for (int w = 0; w < 8; w++) begin
      gen_wave(w % 4, q);
      model(q, emax, emin, ecross, espan);
      run_window(q, $urandom_range(0, 2), -1);
      checks++; if (o_early !== 1'b0 || o_done_now !== 1'b1 || o_done_next !== 1'b0)
        $display("[TB] FAIL rand%0d_done got early=%0b now=%0b next=%0b want 0 1 0", w, o_early, o_done_now, o_done_next); else passes++;
      checks++; if (o_max !== DW'(emax)) $display("[TB] FAIL rand%0d_vmax got %0d want %0d", w, o_max, emax); else passes++;
      checks++; if (o_min !== DW'(emin)) $display("[TB] FAIL rand%0d_vmin got %0d want %0d", w, o_min, emin); else passes++;
      checks++; if (o_vpp !== DW'(emax - emin)) $display("[TB] FAIL rand%0d_vpp got %0d want %0d", w, o_vpp, emax - emin); else passes++;
      checks++; if (o_cross !== CW'(ecross)) $display("[TB] FAIL rand%0d_ncross got %0d want %0d", w, o_cross, ecross); else passes++;
      checks++; if (o_span !== CW'(espan)) $display("[TB] FAIL rand%0d_span got %0d want %0d", w, o_span, espan); else passes++;
      checks++; if (o_nosig !== (ecross < 2)) $display("[TB] FAIL rand%0d_nosig got %0b want %0b", w, o_nosig, ecross < 2); else passes++;
    end
  endtask

  // clr aborts a window without done and keeps the previous results;
  // start together with clr in IDLE does nothing.
  task automatic test_clr_abort();
    int q[$];
    logic seen_done;
    square_wave(q);
    run_window(q, 0, -1);
    seen_done = 1'b0;
    @(negedge clk); start = 1'b1;
    @(negedge clk); start = 1'b0;
    for (int i = 0; i < WIN; i++) begin
      din_vld = 1'b1; din = DW'(q[(i + 5) % WIN]); start = (i == 20); clr = (i == 30);
      @(negedge clk);
      if (done) seen_done = 1'b1;
    end
    start = 1'b0; clr = 1'b0; din_vld = 1'b0;
    repeat (10) begin
      @(negedge clk);
      if (done) seen_done = 1'b1;
    end
    checks++; if (seen_done !== 1'b0) $display("[TB] FAIL clr_no_done got 1 want 0"); else passes++;
    checks++; if (busy !== 1'b0) $display("[TB] FAIL clr_busy got 1 want 0"); else passes++;
    checks++; if (vmax !== 12'd4095 || vmin !== 12'd0 || vpp !== 12'd4095)
      $display("[TB] FAIL clr_hold_vals got %0d/%0d/%0d want 4095/0/4095", vmax, vmin, vpp); else passes++;
    checks++; if (n_cross !== 16'd4 || span !== 16'd48 || no_sig !== 1'b0)
      $display("[TB] FAIL clr_hold_cross got %0d/%0d/%0b want 4/48/0", n_cross, span, no_sig); else passes++;
    @(negedge clk); start = 1'b1; clr = 1'b1;
    @(negedge clk); start = 1'b0; clr = 1'b0;
    checks++; if (busy !== 1'b0) $display("[TB] FAIL start_clr_idle got busy=1 want 0"); else passes++;
  endtask

  // Reset mid-window clears outputs at once; a fresh window then works.
  task automatic test_reset_mid();
    int q[$];
    square_wave(q);
    @(negedge clk); start = 1'b1;
    @(negedge clk); start = 1'b0;
    for (int i = 0; i < 25; i++) begin
      din_vld = 1'b1; din = DW'(q[i]);
      @(negedge clk);
    end
    din_vld = 1'b0;
    #2 rst_n = 1'b0;
    #1;
    checks++; if ({busy, done, vmax, vmin, vpp, n_cross, span, no_sig} !== '0)
      $display("[TB] FAIL rstmid_outputs got busy=%0b vmax=%0d vmin=%0d n=%0d span=%0d want all 0",
               busy, vmax, vmin, n_cross, span); else passes++;
    @(negedge clk); rst_n = 1'b1;
    @(negedge clk);
    test_square(0, "after_rst");
  endtask

  initial begin
    $display("[TB] dds_wave_meter bench start");
    test_reset();
    test_square(0, "square");
    test_square(1, "square_gap");
    test_no_signal();
    test_random();
    test_clr_abort();
    test_reset_mid();
    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

endmodule
